// File: rtl/draw_pkg.sv
// Shared defaults and slicing helper for the circle overlay stage of the VGA chain.
package draw_pkg;

  localparam int COORD_W_DEF = 12;
  localparam int RGB_W_DEF   = 12;
  localparam int RAD_W_DEF   = 8;

  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/circle_hit.sv
// Per-object hit test: stage 1 forms offsets and radius squares, stage 2 the distance compare.
module circle_hit
  import draw_pkg::*;
#(
  parameter int COORD_W = COORD_W_DEF,
  parameter int RAD_W   = RAD_W_DEF,
  parameter int RING_T  = 4
) (
  input  logic               clk_in,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  logic [COORD_W-1:0] xpos,
  input  logic [COORD_W-1:0] ypos,
  input  logic [RAD_W-1:0]   radius,
  input  logic               en,
  input  logic               ring,
  output logic               hit
);

  localparam int DW  = COORD_W + 1;
  localparam int SQW = 2 * DW;
  localparam int D2W = 2 * DW + 1;
  localparam int R2W = 2 * RAD_W;

  logic signed [DW-1:0] dx, dy;
  logic [R2W-1:0]       r2, ri2;
  logic                 en_s1, ring_s1;

  logic [RAD_W-1:0]     r_inner;
  logic [R2W-1:0]       r2_next, ri2_next;
  logic signed [SQW-1:0] dx_sq, dy_sq;
  logic [D2W-1:0]       d2;

  // Inner radius collapses to zero so thin rings degrade to filled discs.
  always_comb begin
    r_inner  = radius - RAD_W'(RING_T);
    r2_next  = R2W'(radius) * R2W'(radius);
    ri2_next = (radius > RAD_W'(RING_T)) ? R2W'(r_inner) * R2W'(r_inner) : '0;
    dx_sq    = SQW'(dx) * SQW'(dx);
    dy_sq    = SQW'(dy) * SQW'(dy);
    d2       = D2W'($unsigned(dx_sq)) + D2W'($unsigned(dy_sq));
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      dx      <= '0;
      dy      <= '0;
      r2      <= '0;
      ri2     <= '0;
      en_s1   <= 1'b0;
      ring_s1 <= 1'b0;
      hit     <= 1'b0;
    end else begin
      dx      <= $signed({1'b0, hcount}) - $signed({1'b0, xpos});
      dy      <= $signed({1'b0, vcount}) - $signed({1'b0, ypos});
      r2      <= r2_next;
      ri2     <= ri2_next;
      en_s1   <= en;
      ring_s1 <= ring;
      hit     <= en_s1 && (d2 <= D2W'(r2)) && (!ring_s1 || (d2 >= D2W'(ri2)));
    end
  end

endmodule

// File: rtl/draw_circle_multi.sv
// Overlays N prioritised filled/ring circles on the background with a fixed 3-cycle latency;
// object parameters are double-buffered and committed on the rising edge of vertical blanking.
module draw_circle_multi
  import draw_pkg::*;
#(
  parameter int                     N_OBJ   = 3,
  parameter int                     COORD_W = COORD_W_DEF,
  parameter int                     RGB_W   = RGB_W_DEF,
  parameter int                     RAD_W   = RAD_W_DEF,
  parameter logic [N_OBJ*RGB_W-1:0] COLORS  = {12'hf00, 12'h0ff, 12'hfff},
  parameter int                     RING_T  = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [COORD_W-1:0]       hcount_in,
  input  logic [COORD_W-1:0]       vcount_in,
  input  logic                     hsync_in,
  input  logic                     vsync_in,
  input  logic                     hblnk_in,
  input  logic                     vblnk_in,
  input  logic [RGB_W-1:0]         rgb_in,
  input  logic [N_OBJ*COORD_W-1:0] xpos_in,
  input  logic [N_OBJ*COORD_W-1:0] ypos_in,
  input  logic [N_OBJ*RAD_W-1:0]   radius_in,
  input  logic [N_OBJ-1:0]         obj_en_in,
  input  logic [N_OBJ-1:0]         ring_in,
  output logic [COORD_W-1:0]       hcount_out,
  output logic [COORD_W-1:0]       vcount_out,
  output logic                     hsync_out,
  output logic                     vsync_out,
  output logic                     hblnk_out,
  output logic                     vblnk_out,
  output logic [RGB_W-1:0]         rgb_out,
  output logic [N_OBJ*COORD_W-1:0] xpos_out,
  output logic [N_OBJ*COORD_W-1:0] ypos_out
);

  logic [N_OBJ*COORD_W-1:0] pend_x, pend_y, act_x, act_y;
  logic [N_OBJ*RAD_W-1:0]   pend_r, act_r;
  logic [N_OBJ-1:0]         pend_en, pend_ring, act_en, act_ring;
  logic                     vblnk_prev;
  logic                     commit;

  assign commit = vblnk_in && !vblnk_prev;

  // vblnk_prev resets high so a reset released inside vblank waits for the next vblank.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      pend_x     <= '0;
      pend_y     <= '0;
      pend_r     <= '0;
      pend_en    <= '0;
      pend_ring  <= '0;
      act_x      <= '0;
      act_y      <= '0;
      act_r      <= '0;
      act_en     <= '0;
      act_ring   <= '0;
      vblnk_prev <= 1'b1;
    end else begin
      pend_x     <= xpos_in;
      pend_y     <= ypos_in;
      pend_r     <= radius_in;
      pend_en    <= obj_en_in;
      pend_ring  <= ring_in;
      vblnk_prev <= vblnk_in;
      if (commit) begin
        act_x    <= pend_x;
        act_y    <= pend_y;
        act_r    <= pend_r;
        act_en   <= pend_en;
        act_ring <= pend_ring;
      end
    end
  end

  logic [N_OBJ-1:0] hit;

  for (genvar g = 0; g < N_OBJ; g++) begin : g_obj
    circle_hit #(
      .COORD_W (COORD_W),
      .RAD_W   (RAD_W),
      .RING_T  (RING_T)
    ) u_hit (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .hcount (hcount_in),
      .vcount (vcount_in),
      .xpos   (act_x[g*COORD_W +: COORD_W]),
      .ypos   (act_y[g*COORD_W +: COORD_W]),
      .radius (act_r[g*RAD_W +: RAD_W]),
      .en     (act_en[g]),
      .ring   (act_ring[g]),
      .hit    (hit[g])
    );
  end

  logic [COORD_W-1:0]       hc_d  [3];
  logic [COORD_W-1:0]       vc_d  [3];
  logic [3:0]               tim_d [3];
  logic [N_OBJ*COORD_W-1:0] xo_d  [3];
  logic [N_OBJ*COORD_W-1:0] yo_d  [3];
  logic [RGB_W-1:0]         rgb_d [2];
  logic [RGB_W-1:0]         rgb_next;

  // Walk from the highest index down so the lowest hitting index wins.
  always_comb begin
    rgb_next = rgb_d[1];
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (hit[i]) rgb_next = COLORS[slice_lsb(i, RGB_W) +: RGB_W];
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        hc_d[i]  <= '0;
        vc_d[i]  <= '0;
        tim_d[i] <= '0;
        xo_d[i]  <= '0;
        yo_d[i]  <= '0;
      end
      rgb_d[0] <= '0;
      rgb_d[1] <= '0;
      rgb_out  <= '0;
    end else begin
      hc_d[0]  <= hcount_in;
      vc_d[0]  <= vcount_in;
      tim_d[0] <= {hsync_in, vsync_in, hblnk_in, vblnk_in};
      xo_d[0]  <= act_x;
      yo_d[0]  <= act_y;
      for (int i = 1; i < 3; i++) begin
        hc_d[i]  <= hc_d[i-1];
        vc_d[i]  <= vc_d[i-1];
        tim_d[i] <= tim_d[i-1];
        xo_d[i]  <= xo_d[i-1];
        yo_d[i]  <= yo_d[i-1];
      end
      rgb_d[0] <= rgb_in;
      rgb_d[1] <= rgb_d[0];
      rgb_out  <= rgb_next;
    end
  end

  assign hcount_out = hc_d[2];
  assign vcount_out = vc_d[2];
  assign {hsync_out, vsync_out, hblnk_out, vblnk_out} = tim_d[2];
  assign xpos_out   = xo_d[2];
  assign ypos_out   = yo_d[2];

endmodule
